// File: rtl/traffic_phase_scheduler.sv
// Two-road traffic phase scheduler: one shared 8-bit down-timer drives the normal
// cycle, pedestrian shortening, emergency all-red preemption and night flashing.
module traffic_phase_scheduler #(
    parameter int G1_TIME     = 40,
    parameter int G2_TIME     = 45,
    parameter int YEL_TIME    = 5,
    parameter int PED_CUT     = 10,
    parameter int FLASH_HALF  = 8,
    parameter int ALLRED_TIME = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       night,
    input  logic       emerg,
    input  logic       ped1,
    input  logic       ped2,
    output logic       R1,
    output logic       Y1,
    output logic       G1,
    output logic       R2,
    output logic       Y2,
    output logic       G2,
    output logic [7:0] remain,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        PH_G1R2   = 3'd0,
        PH_Y1R2   = 3'd1,
        PH_R1G2   = 3'd2,
        PH_R1Y2   = 3'd3,
        PH_FLASH  = 3'd4,
        PH_ALLRED = 3'd5
    } phase_t;

    localparam logic [7:0] G1_LOAD     = 8'(G1_TIME - 1);
    localparam logic [7:0] G2_LOAD     = 8'(G2_TIME - 1);
    localparam logic [7:0] YEL_LOAD    = 8'(YEL_TIME - 1);
    localparam logic [7:0] PED_LOAD    = 8'(PED_CUT - 1);
    localparam logic [7:0] FLASH_LOAD  = 8'(FLASH_HALF - 1);
    localparam logic [7:0] ALLRED_LOAD = 8'(ALLRED_TIME - 1);

    // A green entered with its request already pending is shortened at once.
    function automatic logic [7:0] green_load(input logic [7:0] full, input logic pend);
        if (pend && (full > PED_LOAD)) begin
            return PED_LOAD;
        end else begin
            return full;
        end
    endfunction

    // Lamp vector ordering: {R1, Y1, G1, R2, Y2, G2}; unknown codes fall back to all-red.
    function automatic logic [5:0] lamp_decode(input phase_t ph, input logic blink);
        case (ph)
            PH_G1R2:   return 6'b001_100;
            PH_Y1R2:   return 6'b010_100;
            PH_R1G2:   return 6'b100_001;
            PH_R1Y2:   return 6'b100_010;
            PH_FLASH:  return {1'b0, blink, 1'b0, 1'b0, blink, 1'b0};
            PH_ALLRED: return 6'b100_100;
            default:   return 6'b100_100;
        endcase
    endfunction

    phase_t     phase_r;
    logic [7:0] timer_r;
    logic       pend1_r;
    logic       pend2_r;
    logic       blink_r;
    logic [5:0] lamps_r;

    phase_t     phase_nxt_s;
    logic [7:0] timer_nxt_s;
    logic       pend1_nxt_s;
    logic       pend2_nxt_s;
    logic       blink_nxt_s;
    logic       pend1_eff_s;
    logic       pend2_eff_s;
    logic       timer_zero_s;

    assign timer_zero_s = (timer_r == 8'd0);
    assign pend1_eff_s  = pend1_r | ped1;
    assign pend2_eff_s  = pend2_r | ped2;

    // Next phase, timer, pending requests and flash polarity.
    always_comb begin
        phase_nxt_s = phase_r;
        timer_nxt_s = timer_r - 8'd1;
        pend1_nxt_s = pend1_eff_s;
        pend2_nxt_s = pend2_eff_s;
        blink_nxt_s = 1'b1;
        case (phase_r)
            PH_G1R2: begin
                if (emerg || timer_zero_s) begin
                    phase_nxt_s = PH_Y1R2;
                    timer_nxt_s = YEL_LOAD;
                    pend1_nxt_s = 1'b0;
                end else if (pend1_eff_s && (timer_r > PED_LOAD)) begin
                    timer_nxt_s = PED_LOAD;
                end else begin
                    timer_nxt_s = timer_r - 8'd1;
                end
            end
            PH_R1G2: begin
                if (emerg || timer_zero_s) begin
                    phase_nxt_s = PH_R1Y2;
                    timer_nxt_s = YEL_LOAD;
                    pend2_nxt_s = 1'b0;
                end else if (pend2_eff_s && (timer_r > PED_LOAD)) begin
                    timer_nxt_s = PED_LOAD;
                end else begin
                    timer_nxt_s = timer_r - 8'd1;
                end
            end
            PH_Y1R2, PH_R1Y2: begin
                // Yellow always runs to completion; preemption is decided only at its end.
                if (!timer_zero_s) begin
                    timer_nxt_s = timer_r - 8'd1;
                end else if (emerg) begin
                    phase_nxt_s = PH_ALLRED;
                    timer_nxt_s = ALLRED_LOAD;
                    pend1_nxt_s = ped1;
                    pend2_nxt_s = ped2;
                end else if (night) begin
                    phase_nxt_s = PH_FLASH;
                    timer_nxt_s = FLASH_LOAD;
                    pend1_nxt_s = ped1;
                    pend2_nxt_s = ped2;
                end else if (phase_r == PH_Y1R2) begin
                    phase_nxt_s = PH_R1G2;
                    timer_nxt_s = green_load(G2_LOAD, pend2_eff_s);
                end else begin
                    phase_nxt_s = PH_G1R2;
                    timer_nxt_s = green_load(G1_LOAD, pend1_eff_s);
                end
            end
            PH_FLASH: begin
                blink_nxt_s = blink_r;
                if (emerg) begin
                    phase_nxt_s = PH_ALLRED;
                    timer_nxt_s = ALLRED_LOAD;
                    blink_nxt_s = 1'b1;
                    pend1_nxt_s = ped1;
                    pend2_nxt_s = ped2;
                end else if (!timer_zero_s) begin
                    timer_nxt_s = timer_r - 8'd1;
                end else if (night) begin
                    timer_nxt_s = FLASH_LOAD;
                    blink_nxt_s = ~blink_r;
                end else begin
                    phase_nxt_s = PH_G1R2;
                    timer_nxt_s = green_load(G1_LOAD, pend1_eff_s);
                    blink_nxt_s = 1'b1;
                end
            end
            PH_ALLRED: begin
                if (emerg) begin
                    timer_nxt_s = ALLRED_LOAD;
                end else if (!timer_zero_s) begin
                    timer_nxt_s = timer_r - 8'd1;
                end else begin
                    phase_nxt_s = PH_G1R2;
                    timer_nxt_s = green_load(G1_LOAD, pend1_eff_s);
                end
            end
            default: begin
                phase_nxt_s = PH_G1R2;
                timer_nxt_s = G1_LOAD;
                pend1_nxt_s = 1'b0;
                pend2_nxt_s = 1'b0;
            end
        endcase
    end

    // State registers; lamps are decoded from the next phase so they switch with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_r <= PH_G1R2;
            timer_r <= G1_LOAD;
            pend1_r <= 1'b0;
            pend2_r <= 1'b0;
            blink_r <= 1'b1;
            lamps_r <= lamp_decode(PH_G1R2, 1'b1);
        end else begin
            phase_r <= phase_nxt_s;
            timer_r <= timer_nxt_s;
            pend1_r <= pend1_nxt_s;
            pend2_r <= pend2_nxt_s;
            blink_r <= blink_nxt_s;
            lamps_r <= lamp_decode(phase_nxt_s, blink_nxt_s);
        end
    end

    assign {R1, Y1, G1, R2, Y2, G2} = lamps_r;
    assign remain = timer_r;
    assign phase  = phase_r;

    traffic_phase_scheduler_chk u_chk (
        .clk   (clk),
        .reset (reset),
        .phase (phase_r),
        .R1    (R1),
        .Y1    (Y1),
        .G1    (G1),
        .R2    (R2),
        .Y2    (Y2),
        .G2    (G2)
    );

endmodule

// Lamp-safety invariants observed on the registered outputs.
module traffic_phase_scheduler_chk (
    input logic       clk,
    input logic       reset,
    input logic [2:0] phase,
    input logic       R1,
    input logic       Y1,
    input logic       G1,
    input logic       R2,
    input logic       Y2,
    input logic       G2
);

    // Outside flashing each road shows exactly one lamp; flashing shows only paired yellows.
    always @(posedge clk) begin
        assert (!reset || ((phase <= 3'd5) &&
                ((phase == 3'd4) ? (!R1 && !G1 && !R2 && !G2 && (Y1 == Y2))
                                 : ($onehot({R1, Y1, G1}) && $onehot({R2, Y2, G2})))));
    end

endmodule

// File: doc/traffic_phase_scheduler.md
TRAFFIC_PHASE_SCHEDULER -- requirements
Module: traffic_phase_scheduler

Interface
REQ-001 Parameters SHALL be (name, default, meaning): G1_TIME, 40, road-1 green cycles.
REQ-002 G2_TIME, 45, road-2 green cycles.
REQ-003 YEL_TIME, 5, yellow cycles.
REQ-004 PED_CUT, 10, max remaining green cycles after a pedestrian request.
REQ-005 FLASH_HALF, 8, night-mode yellow half-period in cycles.
REQ-006 ALLRED_TIME, 3, all-red clearance after emergency ends.
REQ-007 Every parameter SHALL be legal in 1..255; the timer is 8 bits.
REQ-008 Ports SHALL be (name, direction, width, meaning): clk  in  1  single clock, rising edge.
REQ-009 reset  in  1  asynchronous, active-low reset.
REQ-010 night  in  1  level; request night flashing mode.
REQ-011 emerg  in  1  level; emergency preemption, all roads red.
REQ-012 ped1  in  1  one-cycle pulse; request early end of road-1 green.
REQ-013 ped2  in  1  one-cycle pulse; request early end of road-2 green.
REQ-014 R1, Y1, G1, R2, Y2, G2  out  1 each  lamp drives, registered.
REQ-015 remain  out  8  current timer value.
REQ-016 phase  out  3  state code: G1R2=0, Y1R2=1, R1G2=2, R1Y2=3, FLASH=4, ALLRED=5.

Function
REQ-017 A single shared 8-bit down-timer SHALL drive all phases: it loads N-1 on phase entry, decrements once per cycle, and the phase exits on the cycle timer==0, so a phase lasts exactly N cycles.
REQ-018 The normal cycle SHALL be G1R2(G1_TIME) -> Y1R2(YEL_TIME) -> R1G2(G2_TIME) -> R1Y2(YEL_TIME) -> G1R2.
REQ-019 Lamp decode SHALL be: G1R2 G1,R2; Y1R2 Y1,R2; R1G2 R1,G2; R1Y2 R1,Y2; ALLRED R1,R2; FLASH Y1=Y2=blink, all others 0.
REQ-020 Outputs SHALL change in the same cycle that phase changes; exactly one lamp per road is lit, except in FLASH.
REQ-021 ped1 SHALL set pend1, held until consumed; ped2/pend2 SHALL behave identically for road 2.
REQ-022 In G1R2 with pend1=1: if timer > PED_CUT-1, load PED_CUT-1 that cycle instead of decrementing; otherwise decrement normally.
REQ-023 pend1 SHALL clear on entry to Y1R2; pend2 SHALL clear on entry to R1Y2.
REQ-024 A ped pulse outside the matching green SHALL stay pending and apply from the first cycle of the next matching green.
REQ-025 emerg=1 in a green phase SHALL move to the matching yellow next cycle with timer=YEL_TIME-1.
REQ-026 Yellow phases SHALL never be truncated.
REQ-027 At yellow end with emerg=1, the next phase SHALL be ALLRED.
REQ-028 ALLRED SHALL hold with timer=ALLRED_TIME-1 while emerg=1; after emerg falls it counts ALLRED_TIME cycles, then enters G1R2.
REQ-029 emerg=1 in FLASH SHALL enter ALLRED next cycle.
REQ-030 At yellow end with night=1 and emerg=0, the next phase SHALL be FLASH.
REQ-031 In FLASH, Y1=Y2 SHALL toggle every FLASH_HALF cycles (first half lit) and the timer reloads each half.
REQ-032 FLASH SHALL exit to G1R2 at the end of a half-period in which night=0.
REQ-033 Priority SHALL be emerg > night > ped; ped pulses in the same cycle as emerg are still latched.
REQ-034 Entering FLASH or ALLRED SHALL clear pend1 and pend2.
REQ-035 night or emerg changes mid-phase SHALL NOT alter the timer, except as stated in REQ-025 and REQ-029.

Reset
REQ-036 reset=0 SHALL immediately set: phase=G1R2, timer=G1_TIME-1, G1=R2=1, other lamps 0, pend1=pend2=0, blink lit.
REQ-037 Reset mid-operation SHALL abort any phase with no residual pending request.
REQ-038 Operation SHALL begin on the first clk edge after reset=1.

Verification
REQ-039 Default params, idle inputs, 190 cycles -> phases 40/5/45/5 cycles, remain 39 at cycle 0, back to G1R2 at cycle 95.
REQ-040 ped1 at cycle 5 of G1R2 -> remain=9 next cycle, Y1 lit 10 cycles later; ped1 at remain=3 -> no change.
REQ-041 ped2 during G1R2 -> R1G2 lasts 10 cycles.
REQ-042 emerg rise in R1G2 -> R1Y2 next cycle for 5 cycles, then ALLRED held; emerg fall -> 3 cycles, then G1R2.
REQ-043 night=1 during Y1R2 -> FLASH after yellow, Y1/Y2 blink 8 on/8 off; night=0 -> G1R2 at half-period end.
REQ-044 reset pulse mid-R1G2 with pend1 set -> G1R2, remain=39, no early truncation.
